// File: rtl/fir_ops_pkg.sv
// Shared definitions for the FIR op sequencer and datapath decode:
// op codes, register map, FSM state encoding and the control bundle.
package fir_ops_pkg;

  localparam int REG_AW = 4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  localparam logic [REG_AW-1:0] R_ACC = 4'd0;
  localparam logic [REG_AW-1:0] R_S0  = 4'd1;
  localparam logic [REG_AW-1:0] R_S1  = 4'd2;
  localparam logic [REG_AW-1:0] R_S2  = 4'd3;
  localparam logic [REG_AW-1:0] R_S3  = 4'd4;
  localparam logic [REG_AW-1:0] R_F0  = 4'd5;
  localparam logic [REG_AW-1:0] R_F1  = 4'd6;
  localparam logic [REG_AW-1:0] R_F2  = 4'd7;
  localparam logic [REG_AW-1:0] R_F3  = 4'd8;
  localparam logic [REG_AW-1:0] R_TMP = 4'd9;

  typedef enum logic [4:0] {
    S_IDLE, S_SH3, S_SH2, S_SH1, S_LD,
    S_ZERO, S_MUL1, S_ADD1, S_MUL2, S_SUB2,
    S_MUL3, S_ADD3, S_MUL4, S_SUB4,
    S_LC0, S_W1, S_LC1, S_W2, S_LC2, S_W3, S_LC3,
    S_EIDLE
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest;
    logic              cnt_up;
    logic              clear;
    logic              modwait;
    logic              err;
  } ctrl_t;

  // Busy control word; flags other than modwait are set by the caller.
  function automatic ctrl_t mk_op(
    input logic [2:0]        op,
    input logic [REG_AW-1:0] s1,
    input logic [REG_AW-1:0] s2,
    input logic [REG_AW-1:0] d
  );
    ctrl_t c;
    c         = '0;
    c.op      = op;
    c.src1    = s1;
    c.src2    = s2;
    c.dest    = d;
    c.modwait = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/fir_op_rom.sv
// Combinational state -> control word decode for the FIR sequencer.
// in: state; out: ctrl {op, src1, src2, dest, cnt_up, clear, modwait, err}.
module fir_op_rom
  import fir_ops_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_SH3:   ctrl = mk_op(OP_COPY, R_S2, R_ACC, R_S3);
      S_SH2:   ctrl = mk_op(OP_COPY, R_S1, R_ACC, R_S2);
      S_SH1:   ctrl = mk_op(OP_COPY, R_S0, R_ACC, R_S1);
      S_LD: begin
        ctrl        = mk_op(OP_LOAD1, R_ACC, R_ACC, R_S0);
        ctrl.cnt_up = 1'b1;
      end
      S_ZERO:  ctrl = mk_op(OP_SUB, R_ACC, R_ACC, R_ACC);
      S_MUL1:  ctrl = mk_op(OP_MUL, R_S0, R_F0, R_TMP);
      S_ADD1:  ctrl = mk_op(OP_ADD, R_ACC, R_TMP, R_ACC);
      S_MUL2:  ctrl = mk_op(OP_MUL, R_S1, R_F1, R_TMP);
      S_SUB2:  ctrl = mk_op(OP_SUB, R_ACC, R_TMP, R_ACC);
      S_MUL3:  ctrl = mk_op(OP_MUL, R_S2, R_F2, R_TMP);
      S_ADD3:  ctrl = mk_op(OP_ADD, R_ACC, R_TMP, R_ACC);
      S_MUL4:  ctrl = mk_op(OP_MUL, R_S3, R_F3, R_TMP);
      S_SUB4:  ctrl = mk_op(OP_SUB, R_ACC, R_TMP, R_ACC);
      S_LC0: begin
        ctrl       = mk_op(OP_LOAD2, R_ACC, R_ACC, R_F0);
        ctrl.clear = 1'b1;
      end
      S_LC1:   ctrl = mk_op(OP_LOAD2, R_ACC, R_ACC, R_F1);
      S_LC2:   ctrl = mk_op(OP_LOAD2, R_ACC, R_ACC, R_F2);
      S_LC3:   ctrl = mk_op(OP_LOAD2, R_ACC, R_ACC, R_F3);
      S_EIDLE: ctrl.err = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/fir_op_sequencer.sv
// FIR control FSM: state register plus next-state logic; outputs via fir_op_rom.
// in: clk, rst, dr, lc, overflow; out: op, src1, src2, dest, cnt_up, clear, modwait, err.
module fir_op_sequencer
  import fir_ops_pkg::*;
#(
  parameter int NREG_W = REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic [2:0]        op,
  output logic [NREG_W-1:0] src1,
  output logic [NREG_W-1:0] src2,
  output logic [NREG_W-1:0] dest,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic              err
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_EIDLE: begin
        // lc has priority over dr
        if (lc)      state_d = S_LC0;
        else if (dr) state_d = S_SH3;
      end
      // dr must be held through the shift/load phase
      S_SH3:  state_d = dr ? S_SH2  : S_EIDLE;
      S_SH2:  state_d = dr ? S_SH1  : S_EIDLE;
      S_SH1:  state_d = dr ? S_LD   : S_EIDLE;
      S_LD:   state_d = dr ? S_ZERO : S_EIDLE;
      S_ZERO: state_d = S_MUL1;
      S_MUL1: state_d = S_ADD1;
      S_ADD1: state_d = overflow ? S_EIDLE : S_MUL2;
      S_MUL2: state_d = S_SUB2;
      S_SUB2: state_d = overflow ? S_EIDLE : S_MUL3;
      S_MUL3: state_d = S_ADD3;
      S_ADD3: state_d = overflow ? S_EIDLE : S_MUL4;
      S_MUL4: state_d = S_SUB4;
      S_SUB4: state_d = overflow ? S_EIDLE : S_IDLE;
      S_LC0:  state_d = S_W1;
      S_W1:   if (lc) state_d = S_LC1;
      S_LC1:  state_d = S_W2;
      S_W2:   if (lc) state_d = S_LC2;
      S_LC2:  state_d = S_W3;
      S_W3:   if (lc) state_d = S_LC3;
      S_LC3:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  fir_op_rom u_rom (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign op      = ctrl.op;
  assign src1    = NREG_W'(ctrl.src1);
  assign src2    = NREG_W'(ctrl.src2);
  assign dest    = NREG_W'(ctrl.dest);
  assign cnt_up  = ctrl.cnt_up;
  assign clear   = ctrl.clear;
  assign modwait = ctrl.modwait;
  assign err     = ctrl.err;

endmodule

// File: tb/tb_fir_op_sequencer.sv
// Scoreboard bench for fir_op_sequencer: expected op words are queued by
// the stimulus and popped by a monitor whenever op is not NOP.
module tb_fir_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, dr, lc, overflow;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  logic       cnt_up, clear, modwait, err;

  int total = 0;
  int bad   = 0;

  typedef logic [18:0] rec_t;
  rec_t exp_q[$];
  rec_t seq_tbl[13];

  always #5 clk = ~clk;

  fir_op_sequencer dut (
    .clk(clk), .rst(rst), .dr(dr), .lc(lc), .overflow(overflow),
    .op(op), .src1(src1), .src2(src2), .dest(dest),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .err(err)
  );

  function automatic rec_t mk(input int o, s1, s2, d, cu, cl, mw, er);
    rec_t r;
    r = {o[2:0], s1[3:0], s2[3:0], d[3:0],
         cu[0], cl[0], mw[0], er[0]};
    return r;
  endfunction

  wire rec_t act = {op, src1, src2, dest, cnt_up, clear, modwait, err};

  // monitor: every issued op must match the head of the scoreboard
  always @(negedge clk) begin
    if (op != 3'd0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_op got=%h (op=%0d dest=%0d) want=none",
                 act, op, dest);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL op_word got=%h want=%h (op=%0d dest=%0d)",
                   act, e, op, dest);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(seq_tbl[i]);
  endtask

  // raise dr from IDLE and hold it through edges 0..4; ends in cycle 5
  task automatic start_sample();
    dr = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    dr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    seq_tbl[0]  = mk(1, 3, 0, 4, 0, 0, 1, 0);
    seq_tbl[1]  = mk(1, 2, 0, 3, 0, 0, 1, 0);
    seq_tbl[2]  = mk(1, 1, 0, 2, 0, 0, 1, 0);
    seq_tbl[3]  = mk(2, 0, 0, 1, 1, 0, 1, 0);
    seq_tbl[4]  = mk(5, 0, 0, 0, 0, 0, 1, 0);
    seq_tbl[5]  = mk(6, 1, 5, 9, 0, 0, 1, 0);
    seq_tbl[6]  = mk(4, 0, 9, 0, 0, 0, 1, 0);
    seq_tbl[7]  = mk(6, 2, 6, 9, 0, 0, 1, 0);
    seq_tbl[8]  = mk(5, 0, 9, 0, 0, 0, 1, 0);
    seq_tbl[9]  = mk(6, 3, 7, 9, 0, 0, 1, 0);
    seq_tbl[10] = mk(4, 0, 9, 0, 0, 0, 1, 0);
    seq_tbl[11] = mk(6, 4, 8, 9, 0, 0, 1, 0);
    seq_tbl[12] = mk(5, 0, 9, 0, 0, 0, 1, 0);

    rst = 1'b1; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_word", 32'(act), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));

    // full sample sequence; overflow in a MUL cycle is ignored
    push_seq(13);
    start_sample();               // cycle 5 (ZERO)
    tick();                       // cycle 6 (MUL1)
    overflow = 1'b1;
    tick();                       // cycle 7
    overflow = 1'b0;
    for (int i = 0; i < 7; i++) tick();  // cycle 14
    chk("full_done_op", 32'(op), 0);
    chk("full_done_modwait", 32'(modwait), 0);
    chk("full_done_err", 32'(err), 0);

    // reset while in MUL2 aborts the sequence
    push_seq(8);
    start_sample();
    for (int i = 0; i < 3; i++) tick();  // cycle 8 (MUL2)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_op", 32'(op), 0);
    chk("rst_mid_modwait", 32'(modwait), 0);
    tick();
    chk("rst_mid_stays_idle", 32'(op), 0);

    // four coefficient loads with 3-cycle gaps; dr in a gap is ignored
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(3, 0, 0, 5 + i, 0, (i == 0), 1, 0));
      lc = 1'b1;
      tick();
      lc = 1'b0;
      tick();
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          chk("gap_modwait", 32'(modwait), 0);
          chk("gap_op", 32'(op), 0);
          dr = (g == 1);
          tick();
          dr = 1'b0;
        end
      end
    end
    chk("lc_done_op", 32'(op), 0);
    chk("lc_done_modwait", 32'(modwait), 0);

    // dr dropped in SH2 -> EIDLE, then recovery
    push_seq(2);
    dr = 1'b1;
    tick(); tick();               // cycle 2 (SH2)
    dr = 1'b0;
    tick();                       // cycle 3
    chk("drop_err", 32'(err), 1);
    chk("drop_op", 32'(op), 0);
    chk("drop_modwait", 32'(modwait), 0);
    tick();
    chk("eidle_hold_err", 32'(err), 1);
    push_seq(13);
    start_sample();
    chk("recover_err", 32'(err), 0);
    for (int i = 0; i < 9; i++) tick();  // cycle 14
    chk("recover_done_op", 32'(op), 0);
    chk("recover_done_err", 32'(err), 0);

    // overflow in SUB2 -> write issued, then EIDLE
    push_seq(9);
    start_sample();
    for (int i = 0; i < 4; i++) tick();  // cycle 9 (SUB2)
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    chk("ovf_err", 32'(err), 1);
    chk("ovf_op", 32'(op), 0);
    chk("ovf_modwait", 32'(modwait), 0);

    // lc and dr together from EIDLE: lc wins, err drops
    exp_q.push_back(mk(3, 0, 0, 5, 0, 1, 1, 0));
    lc = 1'b1; dr = 1'b1;
    tick();
    lc = 1'b0; dr = 1'b0;
    chk("prio_err", 32'(err), 0);
    chk("prio_dest", 32'(dest), 5);
    tick();
    chk("prio_w1_op", 32'(op), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // lc and dr together from IDLE
    exp_q.push_back(mk(3, 0, 0, 5, 0, 1, 1, 0));
    lc = 1'b1; dr = 1'b1;
    tick();
    lc = 1'b0; dr = 1'b0;
    chk("idle_prio_op", 32'(op), 3);
    tick(); tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
